len5_ras: RTL and testbench
===========================

Name: len5_ras

Overview:
- Parametrised return address stack (RAS) for the LEN5 fetch-stage branch predictor; replaces the fixed-depth RAS sized by RAS_DEPTH.
- Calls push the return address; returns pop it and expose the predicted target.
- Circular storage: overflow silently overwrites the oldest entry; underflow is reported, never corrupts state.
- Optional tos/count checkpointing for fast recovery after branch mispredictions.

Parameters:
- DEPTH, 8, number of entries; power of 2, >= 2
- ADDR_W, 64, width of a stored return address
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter (derived, do not override)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  empty the stack (pipeline flush / exception)
- push_i  in  1  call detected; push push_addr_i
- pop_i  in  1  return detected; pop the top entry
- push_addr_i  in  ADDR_W  return address to push
- top_valid_o  out  1  stack non-empty
- top_addr_o  out  ADDR_W  current top-of-stack address (predicted return target)
- count_o  out  CNT_W  current occupancy, 0..DEPTH
- overflow_o  out  1  1-cycle pulse: a push overwrote the oldest entry
- underflow_o  out  1  1-cycle pulse: pop requested on an empty stack
- ckpt_save_i  in  1  (LEN5_RAS_CKPT_EN only) save tos/count snapshot
- ckpt_restore_i  in  1  (LEN5_RAS_CKPT_EN only) restore tos/count from snapshot

Behaviour:
- Clock/reset: one clock, clk_i; reset asynchronous, active-high, on rst_i.
- State: mem[DEPTH] x ADDR_W; tos pointer ($clog2(DEPTH) bits, wraps modulo DEPTH); count (CNT_W); overflow/underflow pulse registers.
- Reset, including mid-operation: all mem = 0, tos = 0, count = 0, overflow_o = 0, underflow_o = 0. Outputs after reset: top_valid_o = 0, top_addr_o = 0, count_o = 0.
- Outputs: top_addr_o = mem[tos], combinational from registers. top_valid_o = (count != 0). count_o = count.
- Operations take effect at the next rising edge; the new top is visible the cycle after push/pop (1-cycle latency).
- Priority per cycle: flush_i > ckpt_restore_i > push/pop.
- flush_i: tos = 0, count = 0; mem not cleared; no pulses; push/pop that cycle ignored.
- Push only: tos = tos+1 mod DEPTH; mem[tos+1] = push_addr_i.
  - count < DEPTH: count += 1.
  - count == DEPTH: count stays DEPTH; oldest entry overwritten; overflow_o = 1 next cycle.
- Pop only:
  - count > 0: tos = tos-1 mod DEPTH; count -= 1; popped entry not cleared.
  - count == 0: no state change; underflow_o = 1 next cycle.
- Push and pop together (return followed by call):
  - count > 0: mem[tos] = push_addr_i; tos and count unchanged; no pulses.
  - count == 0: behaves as push only (count = 1); no underflow.
- Pulse outputs stay high for exactly one cycle per event and deassert the next cycle absent a new event.
- Wrap-around: tos DEPTH-1 -> 0 on push; 0 -> DEPTH-1 on pop, with the count guard above.

Optional Feature:
- Macro LEN5_RAS_CKPT_EN.
- Defined:
  - ckpt_* ports exist; adds snapshot registers ckpt_tos and ckpt_cnt (reset 0).
  - ckpt_save_i captures the pre-edge tos/count; any push/pop in the same cycle still applies to live state.
  - ckpt_restore_i loads tos = ckpt_tos and count = ckpt_cnt; push/pop that cycle ignored; no pulses.
  - Save and restore in the same cycle: restore wins; snapshot unchanged.
  - flush_i overrides restore; the snapshot is unaffected by flush.
  - Entry contents are not checkpointed; entries overwritten after the save are not recovered.
- Not defined: ckpt_* ports and snapshot registers are absent; behaviour otherwise identical.

Test Plan:
- DEPTH=4: reset, push 0x100, 0x200, 0x300 on consecutive cycles -> count_o 1,2,3; top_addr_o 0x100,0x200,0x300; top_valid_o 1 from the cycle after the first push.
- DEPTH=4: push 0x10..0x50 (5 pushes) -> 5th push gives overflow_o pulse for one cycle, count_o = 4; then pop x4 -> top sequence 0x50, 0x40, 0x30, 0x20, then top_valid_o = 0.
- Empty stack, pop_i = 1 -> underflow_o = 1 for one cycle, count_o = 0, tos unchanged; then push+pop with 0xAA -> count_o = 1, top = 0xAA.
- Stack {0x100, 0x200}, push+pop with 0x999 -> count_o stays 2, top = 0x999; then pop -> top = 0x100.
- Stack of 3 entries, assert flush_i together with push_i -> count_o = 0 and top_valid_o = 0 next cycle, no overflow_o; assert rst_i asynchronously mid-push -> all outputs 0 immediately.
- LEN5_RAS_CKPT_EN: count=2 (top 0x200), ckpt_save_i + pop, then pop, then ckpt_restore_i + push 0x7 -> after restore count_o = 2, top = 0x200, push ignored.

Source files
------------

// File: rtl/len5_ras.sv
// Return address stack for the LEN5 fetch-stage predictor: circular storage, overflow drops the oldest entry.
// Define LEN5_RAS_CKPT_EN to add tos/count checkpoint save and restore for misprediction recovery.
module len5_ras #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_addr_i,
`ifdef LEN5_RAS_CKPT_EN
    input  logic              ckpt_save_i,
    input  logic              ckpt_restore_i,
`endif
    output logic              top_valid_o,
    output logic [ADDR_W-1:0] top_addr_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  tos_reg, tos_next, wr_idx;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              wr_en;
    logic              ov_reg, ov_next, un_reg, un_next;

`ifdef LEN5_RAS_CKPT_EN
    logic [PTR_W-1:0]  ckpt_tos_reg;
    logic [CNT_W-1:0]  ckpt_cnt_reg;
`endif

    always_comb begin
        tos_next = tos_reg;
        cnt_next = cnt_reg;
        wr_en    = 1'b0;
        wr_idx   = tos_reg;
        ov_next  = 1'b0;
        un_next  = 1'b0;
        if (flush_i) begin
            tos_next = '0;
            cnt_next = '0;
        end
`ifdef LEN5_RAS_CKPT_EN
        else if (ckpt_restore_i) begin
            tos_next = ckpt_tos_reg;
            cnt_next = ckpt_cnt_reg;
        end
`endif
        else if (push_i && pop_i && (cnt_reg != '0)) begin
            // Return then call: the new return address replaces the current top in place.
            wr_en = 1'b1;
        end else if (push_i) begin
            tos_next = tos_reg + PTR_W'(1);
            wr_idx   = tos_reg + PTR_W'(1);
            wr_en    = 1'b1;
            if (cnt_reg == FULL) ov_next = 1'b1;
            else                 cnt_next = cnt_reg + CNT_W'(1);
        end else if (pop_i) begin
            if (cnt_reg != '0) begin
                tos_next = tos_reg - PTR_W'(1);
                cnt_next = cnt_reg - CNT_W'(1);
            end else begin
                un_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            tos_reg <= '0;
            cnt_reg <= '0;
            ov_reg  <= 1'b0;
            un_reg  <= 1'b0;
        end else begin
            if (wr_en) mem[wr_idx] <= push_addr_i;
            tos_reg <= tos_next;
            cnt_reg <= cnt_next;
            ov_reg  <= ov_next;
            un_reg  <= un_next;
        end
    end

`ifdef LEN5_RAS_CKPT_EN
    // Snapshot is untouched by flush, and a simultaneous restore takes precedence over save.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ckpt_tos_reg <= '0;
            ckpt_cnt_reg <= '0;
        end else if (ckpt_save_i && !ckpt_restore_i && !flush_i) begin
            ckpt_tos_reg <= tos_reg;
            ckpt_cnt_reg <= cnt_reg;
        end
    end
`endif

    assign top_addr_o  = mem[tos_reg];
    assign top_valid_o = (cnt_reg != '0);
    assign count_o     = cnt_reg;
    assign overflow_o  = ov_reg;
    assign underflow_o = un_reg;

endmodule

// File: tb/tb_len5_ras.sv
// Scoreboard bench for len5_ras at DEPTH=4; a reference stack model queues expected outputs per cycle.
// Checkpoint scenario compiles in when LEN5_RAS_CKPT_EN is defined.
module tb_len5_ras;

    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int OW    = AW + CW + 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i, push_i, pop_i;
    logic [AW-1:0] push_addr_i;
    logic          ckpt_save_i, ckpt_restore_i;
    logic          top_valid_o;
    logic [AW-1:0] top_addr_o;
    logic [CW-1:0] count_o;
    logic          overflow_o, underflow_o;

    len5_ras #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_i(flush_i),
        .push_i(push_i),
        .pop_i(pop_i),
        .push_addr_i(push_addr_i),
`ifdef LEN5_RAS_CKPT_EN
        .ckpt_save_i(ckpt_save_i),
        .ckpt_restore_i(ckpt_restore_i),
`endif
        .top_valid_o(top_valid_o),
        .top_addr_o(top_addr_o),
        .count_o(count_o),
        .overflow_o(overflow_o),
        .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;

    logic [OW-1:0] sb[$];
    logic [OW-1:0] obs, exp_v;

    logic [AW-1:0] m_mem [DEPTH];
    int            m_tos, m_cnt, m_ctos, m_ccnt;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_tos = 0; m_cnt = 0; m_ctos = 0; m_ccnt = 0;
    endfunction

    // Applies one cycle of stimulus to the reference stack and returns the outputs expected after the edge.
    function automatic logic [OW-1:0] model_step(input logic fl, input logic pu, input logic po,
                                                 input logic [AW-1:0] a, input logic sv, input logic rs);
        logic ov, un;
        ov = 1'b0; un = 1'b0;
        if (fl) begin
            m_tos = 0; m_cnt = 0;
        end
`ifdef LEN5_RAS_CKPT_EN
        else if (rs) begin
            m_tos = m_ctos; m_cnt = m_ccnt;
        end
`endif
        else begin
`ifdef LEN5_RAS_CKPT_EN
            if (sv) begin
                m_ctos = m_tos; m_ccnt = m_cnt;
            end
`endif
            if (pu && po && m_cnt > 0) begin
                m_mem[m_tos] = a;
            end else if (pu) begin
                m_tos = (m_tos + 1) % DEPTH;
                m_mem[m_tos] = a;
                if (m_cnt == DEPTH) ov = 1'b1;
                else m_cnt++;
            end else if (po) begin
                if (m_cnt > 0) begin
                    m_tos = (m_tos + DEPTH - 1) % DEPTH;
                    m_cnt--;
                end else begin
                    un = 1'b1;
                end
            end
        end
        return {(m_cnt != 0), m_mem[m_tos], CW'(m_cnt), ov, un};
    endfunction

    // Drives one cycle, queues the expected result, and returns #1 after the active edge with inputs idle.
    task automatic drive(input logic fl, input logic pu, input logic po, input logic [AW-1:0] a,
                         input logic sv = 1'b0, input logic rs = 1'b0);
        flush_i = fl; push_i = pu; pop_i = po; push_addr_i = a;
        ckpt_save_i = sv; ckpt_restore_i = rs;
        sb.push_back(model_step(fl, pu, po, a, sv, rs));
        @(posedge clk_i);
        #1;
        flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; push_addr_i = '0;
        ckpt_save_i = 1'b0; ckpt_restore_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({top_valid_o, top_addr_o, count_o, overflow_o, underflow_o} !== '0) begin
            $display("FAIL reset_outputs: got %h need 0", {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o});
        end else passes++;
        $display("reset: valid=%0b top=%h count=%0d", top_valid_o, top_addr_o, count_o);
    endtask

    task automatic test_push_seq();
        logic [AW-1:0] addrs [3];
        addrs[0] = 64'h100; addrs[1] = 64'h200; addrs[2] = 64'h300;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, addrs[i]);
            obs = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v || count_o !== CW'(i + 1) || top_addr_o !== addrs[i] || top_valid_o !== 1'b1)
                $display("FAIL push_seq[%0d]: got count=%0d top=%h valid=%0b need count=%0d top=%h valid=1",
                         i, count_o, top_addr_o, top_valid_o, i + 1, addrs[i]);
            else passes++;
            $display("push %h: count=%0d top=%h", addrs[i], count_o, top_addr_o);
        end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] tops [4];
        tops[0] = 64'h50; tops[1] = 64'h40; tops[2] = 64'h30; tops[3] = 64'h20;
        drive(1'b1, 1'b0, 1'b0, '0);
        void'(sb.pop_front());
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, AW'(i * 16));
            obs = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v || overflow_o !== (i == 5))
                $display("FAIL overflow_push[%0d]: got %h ovf=%0b need %h ovf=%0b", i, obs, overflow_o, exp_v, i == 5);
            else passes++;
            $display("push %h: count=%0d ovf=%0b", i * 16, count_o, overflow_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (top_addr_o !== tops[i] || top_valid_o !== 1'b1)
                $display("FAIL pop_top[%0d]: got top=%h valid=%0b need top=%h valid=1", i, top_addr_o, top_valid_o, tops[i]);
            else passes++;
            drive(1'b0, 1'b0, 1'b1, '0);
            obs = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v || overflow_o !== 1'b0 || count_o !== CW'(3 - i))
                $display("FAIL pop_state[%0d]: got %h need %h", i, obs, exp_v);
            else passes++;
            $display("pop: count=%0d top=%h valid=%0b", count_o, top_addr_o, top_valid_o);
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, 1'b0, 1'b1, '0);
        obs = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || underflow_o !== 1'b1 || count_o !== '0)
            $display("FAIL underflow_pulse: got %h unf=%0b need %h unf=1", obs, underflow_o, exp_v);
        else passes++;
        $display("pop empty: unf=%0b count=%0d", underflow_o, count_o);
        drive(1'b0, 1'b1, 1'b1, 64'hAA);
        obs = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || underflow_o !== 1'b0 || count_o !== CW'(1) || top_addr_o !== 64'hAA)
            $display("FAIL pushpop_empty: got count=%0d top=%h unf=%0b need count=1 top=aa unf=0", count_o, top_addr_o, underflow_o);
        else passes++;
        $display("push+pop aa on empty: count=%0d top=%h", count_o, top_addr_o);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a [4];
        logic          pu [4], po [4];
        a[0] = 64'h100; a[1] = 64'h200; a[2] = 64'h999; a[3] = '0;
        pu[0] = 1; pu[1] = 1; pu[2] = 1; pu[3] = 0;
        po[0] = 0; po[1] = 0; po[2] = 1; po[3] = 1;
        drive(1'b1, 1'b0, 1'b0, '0);
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, pu[i], po[i], a[i]);
            obs = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) $display("FAIL back_to_back[%0d]: got %h need %h", i, obs, exp_v);
            else passes++;
            $display("b2b push=%0b pop=%0b addr=%h: count=%0d top=%h", pu[i], po[i], a[i], count_o, top_addr_o);
        end
        checks++;
        if (count_o !== CW'(1) || top_addr_o !== 64'h100)
            $display("FAIL replace_then_pop: got count=%0d top=%h need count=1 top=100", count_o, top_addr_o);
        else passes++;
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, AW'(64'h1000 + i));
            void'(sb.pop_front());
        end
        drive(1'b1, 1'b1, 1'b0, 64'hDEAD);
        obs = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || count_o !== '0 || top_valid_o !== 1'b0 || overflow_o !== 1'b0)
            $display("FAIL flush_push: got count=%0d valid=%0b ovf=%0b need 0 0 0", count_o, top_valid_o, overflow_o);
        else passes++;
        $display("flush+push: count=%0d valid=%0b", count_o, top_valid_o);
        drive(1'b0, 1'b1, 1'b0, 64'h77);
        void'(sb.pop_front());
        push_i = 1'b1; push_addr_i = 64'h55;
        #3 rst_i = 1'b1;
        #1;
        checks++;
        if ({top_valid_o, top_addr_o, count_o, overflow_o, underflow_o} !== '0)
            $display("FAIL async_reset: got %h need 0", {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o});
        else passes++;
        $display("async reset mid-push: valid=%0b top=%h count=%0d", top_valid_o, top_addr_o, count_o);
        @(posedge clk_i);
        #1;
        push_i = 1'b0; push_addr_i = '0;
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  {$urandom, $urandom}, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            obs = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errs++;
                if (errs <= 5) $display("FAIL random[%0d]: got %h need %h", i, obs, exp_v);
            end else passes++;
        end
        $display("random: 300 cycles, %0d differing", errs);
    endtask

`ifdef LEN5_RAS_CKPT_EN
    task automatic test_ckpt();
        drive(1'b1, 1'b0, 1'b0, '0);
        void'(sb.pop_front());
        drive(1'b0, 1'b1, 1'b0, 64'h100); void'(sb.pop_front());
        drive(1'b0, 1'b1, 1'b0, 64'h200); void'(sb.pop_front());
        drive(1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
        obs = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || count_o !== CW'(1)) $display("FAIL ckpt_save_pop: got %h need %h", obs, exp_v);
        else passes++;
        drive(1'b0, 1'b0, 1'b1, '0);
        void'(sb.pop_front());
        drive(1'b0, 1'b1, 1'b0, 64'h7, 1'b0, 1'b1);
        obs = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || count_o !== CW'(2) || top_addr_o !== 64'h200)
            $display("FAIL ckpt_restore: got count=%0d top=%h need count=2 top=200", count_o, top_addr_o);
        else passes++;
        $display("ckpt restore: count=%0d top=%h", count_o, top_addr_o);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; push_addr_i = '0;
        ckpt_save_i = 1'b0; ckpt_restore_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        rst_i = 1'b0;
        test_push_seq();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_flush_reset();
        test_random();
`ifdef LEN5_RAS_CKPT_EN
        test_ckpt();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
